// File: rtl/whiten_sequencer_pkg.sv
// Shared definitions for the BLE-style whitening sequencer: FSM state
// encoding, default prefix length and the whitening LFSR seed construction.
package whiten_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_BYPASS = 2'd2,
        ST_WHITEN = 2'd3
    } state_e;

    // 8 preamble bits + 32 access-address bits are sent unwhitened
    localparam int PREFIX_BITS_DEFAULT = 40;

    localparam int   LFSR_W        = 7;
    // Constant '1' placed in LFSR position 0 on every load
    localparam logic LFSR_SEED_BIT = 1'b1;

    // Position 0 holds the constant one, positions 1..6 hold channel bits
    // 5..0, so channel bit 0 lands in position 6 (the output tap).
    function automatic logic [LFSR_W-1:0] lfsr_seed(input logic [5:0] ch);
        logic [LFSR_W-1:0] s;
        s[0] = LFSR_SEED_BIT;
        for (int i = 0; i < 6; i++) begin
            s[i+1] = ch[5-i];
        end
        return s;
    endfunction

endpackage

// File: rtl/whiten_sequencer_if.sv
// Serial bit stream bus of the whitening sequencer: input bit stream with
// ready/valid/last, output bit stream with valid/last.
interface whiten_sequencer_if;
    logic in_bit;
    logic in_valid;
    logic in_last;
    logic in_ready;
    logic out_bit;
    logic out_valid;
    logic out_last;

    // Bit source / sink side (e.g. packet framer and modulator)
    modport master (
        output in_bit, in_valid, in_last,
        input  in_ready, out_bit, out_valid, out_last
    );

    // Sequencer side
    modport slave (
        input  in_bit, in_valid, in_last,
        output in_ready, out_bit, out_valid, out_last
    );
endinterface

// File: rtl/whiten_sequencer_scramble_core.sv
// scramble_core: 7-bit whitening LFSR, polynomial x^7 + x^4 + 1.
// Output tap is position 6; it feeds back into position 0 and is XORed into
// position 4. Loaded from the channel number, advanced once per whitened bit.
module scramble_core
    import whiten_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       load_i,
    input  logic [5:0] channel_i,
    input  logic       adv_i,
    output logic       wbit_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Next LFSR value: reseed on load, shift on advance, otherwise hold
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = lfsr_seed(channel_i);
        end else if (adv_i) begin
            lfsr_d = {lfsr_q[5], lfsr_q[4], lfsr_q[3] ^ lfsr_q[6],
                      lfsr_q[2], lfsr_q[1], lfsr_q[0], lfsr_q[6]};
        end
    end

    // LFSR state; always reseeded before use, so it carries no reset
    always_ff @(posedge clk) begin
        lfsr_q <= lfsr_d;
    end

    assign wbit_o = lfsr_q[6];

endmodule

// File: rtl/whiten_sequencer.sv
// whiten_sequencer: passes the packet prefix (preamble + access address)
// raw, then whitens the remaining bits with the channel-seeded LFSR.
// One register stage for both paths, so the prefix/whiten boundary has no
// bubble. Optional build macro WHITEN_SEQUENCER_BYPASS_EN adds the
// whiten_disable input (sampled on pkt_start) that sends payload raw.
module whiten_sequencer
    import whiten_sequencer_pkg::*;
#(
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int PREFIX_BITS              = PREFIX_BITS_DEFAULT
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
    input  logic                                pkt_start,
`ifdef WHITEN_SEQUENCER_BYPASS_EN
    input  logic                                whiten_disable,
`endif
    whiten_sequencer_if.slave                   bus,
    output logic                                busy,
    output logic                                err_short
);

    localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
    localparam logic [1:0] S_LOAD   = 2'(ST_LOAD);
    localparam logic [1:0] S_BYPASS = 2'(ST_BYPASS);
    localparam logic [1:0] S_WHITEN = 2'(ST_WHITEN);

    localparam int               CNT_W    = $clog2(PREFIX_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PREFIX_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_BITS - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       chan_q, chan_d;
    logic             out_bit_q, out_bit_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             err_q, err_d;
    logic             ready_w, accept_w, load_w, adv_w, wbit_w, whiten_on_w;

`ifdef WHITEN_SEQUENCER_BYPASS_EN
    logic             dis_q, dis_d;
    assign whiten_on_w = ~dis_q;
`else
    assign whiten_on_w = 1'b1;
`endif

    assign ready_w  = ~rst && ((state_q == S_BYPASS) || (state_q == S_WHITEN));
    assign accept_w = bus.in_valid && ready_w;

    scramble_core u_scramble (
        .clk       (clk),
        .load_i    (load_w),
        .channel_i (chan_q),
        .adv_i     (adv_w),
        .wbit_o    (wbit_w)
    );

    // Sequencer next state: packet start/abort, prefix counting, output bit
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        chan_d      = chan_q;
        out_bit_d   = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        err_d       = 1'b0;
        load_w      = 1'b0;
        adv_w       = 1'b0;
`ifdef WHITEN_SEQUENCER_BYPASS_EN
        dis_d       = dis_q;
`endif
        if (pkt_start) begin
            // Start or abort: any bit offered this cycle is dropped
            state_d = S_LOAD;
            cnt_d   = '0;
            chan_d  = channel_number[5:0];
`ifdef WHITEN_SEQUENCER_BYPASS_EN
            dis_d   = whiten_disable;
`endif
        end else begin
            case (state_q)
                S_LOAD: begin
                    load_w  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_BYPASS;
                end
                S_BYPASS: begin
                    if (accept_w) begin
                        out_valid_d = 1'b1;
                        out_bit_d   = bus.in_bit;
                        out_last_d  = bus.in_last;
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (bus.in_last) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = S_WHITEN;
                        end
                    end
                end
                S_WHITEN: begin
                    if (accept_w) begin
                        out_valid_d = 1'b1;
                        out_bit_d   = bus.in_bit ^ (wbit_w & whiten_on_w);
                        out_last_d  = bus.in_last;
                        adv_w       = 1'b1;
                        if (bus.in_last) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Control and output registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    // Per-packet configuration captured on pkt_start
    always_ff @(posedge clk) begin
        chan_q <= chan_d;
`ifdef WHITEN_SEQUENCER_BYPASS_EN
        dis_q  <= dis_d;
`endif
    end

    assign bus.in_ready  = ready_w;
    assign bus.out_bit   = out_bit_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign busy          = ~rst && (state_q != S_IDLE);
    assign err_short     = err_q;

endmodule

// File: doc/whiten_sequencer.md
WHITEN_SEQUENCER -- requirements
Module: whiten_sequencer

Interface
REQ-001 Parameters (name, default, meaning): CHANNEL_NUMBER_BIT_WIDTH, 6, channel index width; PREFIX_BITS, 40, leading bits passed unwhitened (8 preamble + 32 access address).
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 channel_number  input  CHANNEL_NUMBER_BIT_WIDTH  RF channel; sampled on the pkt_start cycle.
REQ-005 pkt_start  input  1  one-cycle pulse that begins a packet.
REQ-006 in_bit, in_valid, in_last  input  1 each  serial packet bit, qualifier, final-bit marker.
REQ-007 in_ready  output  1  high when a bit is accepted this cycle.
REQ-008 out_bit, out_valid, out_last  output  1 each  transmitted bit, qualifier, final-bit marker.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 err_short  output  1  one-cycle pulse when in_last is accepted before the prefix completes.

Function
REQ-011 FSM states: IDLE, LOAD, BYPASS, WHITEN.
REQ-012 IDLE -> LOAD on pkt_start; channel_number is latched and a one-cycle load is issued to the scrambler in LOAD.
REQ-013 LOAD -> BYPASS unconditionally after one cycle; in_ready is 0 in IDLE and LOAD.
REQ-014 BYPASS: in_ready=1; accepted bits pass raw; the prefix counter increments per accepted bit; -> WHITEN after PREFIX_BITS accepted bits.
REQ-015 WHITEN: in_ready=1; accepted bits go to the scrambler; out_bit = in_bit XOR whitening bit.
REQ-016 Whitening LFSR: 7 bits x^7+x^4+1; loaded as {ch[0..5] reversed, 1}; advances only on accepted WHITEN bits.
REQ-017 Accepted in_last in WHITEN -> IDLE next cycle; out_last accompanies the matching output bit.
REQ-018 Accepted in_last in BYPASS -> IDLE, with out_last on that bit and err_short pulsed in the same cycle as that out_valid.
REQ-019 Latency: exactly 1 cycle from accepted input to out_valid in both BYPASS and WHITEN; raw and whitened paths are aligned, so there is no bubble at the prefix/whiten boundary.
REQ-020 out_valid=0 in every cycle without an accepted input the previous cycle.
REQ-021 pkt_start while busy aborts the current packet, re-latches the channel and enters LOAD; there is no out_last for the aborted packet, and a bit accepted on the pkt_start cycle is discarded.
REQ-022 in_valid in IDLE or LOAD is ignored and produces no output.
REQ-023 The prefix counter is sized clog2(PREFIX_BITS+1) and saturates; it never wraps.

Reset
REQ-024 rst clears the FSM to IDLE and clears the prefix counter.
REQ-025 rst drives out_bit, out_valid, out_last, in_ready, busy and err_short to 0.
REQ-026 rst mid-packet discards all in-flight state, and the next cycle produces out_valid=0.

Configuration
REQ-027 Macro WHITEN_SEQUENCER_BYPASS_EN adds input whiten_disable (1 bit, sampled on pkt_start).
REQ-028 With the macro defined and whiten_disable=1, WHITEN passes bits raw and the LFSR still advances; with the macro undefined, the port is absent and whitening is always active.

Structure
REQ-029 Shared package holds the FSM state enum, the PREFIX_BITS default and the LFSR seed-bit constant.
REQ-030 The whitening LFSR is one instantiated sub-module, scramble_core, driven by this block's load and valid strobes.

Verification
REQ-031 Channel 37, 40 prefix ones then 8 payload zeros -> 40 raw ones, then payload out 1,0,1,1,0,0,0,1, out_last on bit 48.
REQ-032 in_last on prefix bit 20 -> 20 raw outputs, out_last and err_short on output 20, busy=0 next cycle.
REQ-033 pkt_start at payload bit 5, channel 0 -> no out_last for packet 1, in_ready=0 for 1 cycle, and new whitening starts from seed 0000001.
REQ-034 in_valid toggling 1/0 through the prefix/whiten boundary -> each output exactly 1 cycle after its input, with the same LFSR sequence as continuous input.
REQ-035 rst asserted at payload bit 3 -> all outputs 0 next cycle, and the following packet is correct from its start.
REQ-036 Macro defined, whiten_disable=1, channel 37 -> payload output equals payload input bit-for-bit.
